// File: rtl/scr_pkg.sv
// Shared definitions for the scrambler frame sequencer: state codes, field
// lengths and the SIGNAL-field bit layout.
package scr_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SIGNAL  = 3'd1,
      ST_SERVICE = 3'd2,
      ST_DATA    = 3'd3,
      ST_TAIL    = 3'd4,
      ST_PAD     = 3'd5,
      ST_DONE    = 3'd6
   } state_e;

   localparam int SIGNAL_BITS  = 24;
   localparam int SERVICE_BITS = 16;
   localparam int TAIL_BITS    = 6;

   localparam int SIG_RATE_LO = 0;
   localparam int SIG_LEN_LO  = 5;
   localparam int SIG_PARITY  = 17;

   // Bit i of the returned word is the i-th transmitted SIGNAL bit.
   function automatic logic [SIGNAL_BITS-1:0] signal_word(input logic [3:0]  rate,
                                                           input logic [11:0] len);
      logic [SIGNAL_BITS-1:0] w;
      w = '0;
      w[SIG_RATE_LO +: 4] = {rate[0], rate[1], rate[2], rate[3]};
      w[SIG_LEN_LO +: 12] = len;
      w[SIG_PARITY]       = ^w[SIG_PARITY-1:0];
      return w;
   endfunction

endpackage

// File: rtl/scr_byte_serializer.sv
// Byte-to-bit path: one-byte hold register feeding an 8-bit shift register,
// plus the upstream fetch handshake and fetched-byte counter.
module scr_byte_serializer #(
   parameter int LEN_W = 12
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clear_i,
   input  logic             fetch_en_i,
   input  logic [LEN_W-1:0] len_i,
   input  logic [7:0]       src_data_i,
   input  logic             src_valid_i,
   output logic             src_ready_o,
   output logic             bit_o,
   output logic             bit_avail_o,
   input  logic             advance_i
);

   logic [7:0]       hold_q, hold_d;
   logic [7:0]       shift_q, shift_d;
   logic             hold_full_q, hold_full_d;
   logic [3:0]       sh_cnt_q, sh_cnt_d;
   logic [LEN_W-1:0] fetched_q, fetched_d;
   logic             fetch;
   logic             load;

   assign src_ready_o = !hold_full_q && fetch_en_i && (fetched_q < len_i);
   assign fetch       = src_ready_o && src_valid_i;
   assign load        = advance_i && (sh_cnt_q == 4'd0);

   // At a byte boundary the first bit is taken straight from the hold register.
   assign bit_avail_o = (sh_cnt_q != 4'd0) || hold_full_q;
   assign bit_o       = (sh_cnt_q != 4'd0) ? shift_q[0] : hold_q[0];

   always_comb begin
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      shift_d     = shift_q;
      sh_cnt_d    = sh_cnt_q;
      fetched_d   = fetched_q;
      if (advance_i) begin
         if (load) begin
            shift_d     = {1'b0, hold_q[7:1]};
            sh_cnt_d    = 4'd7;
            hold_full_d = 1'b0;
         end else begin
            shift_d  = {1'b0, shift_q[7:1]};
            sh_cnt_d = sh_cnt_q - 4'd1;
         end
      end
      if (fetch) begin
         hold_d      = src_data_i;
         hold_full_d = 1'b1;
         fetched_d   = fetched_q + 1'b1;
      end
      if (clear_i) begin
         hold_full_d = 1'b0;
         sh_cnt_d    = '0;
         fetched_d   = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         hold_full_q <= 1'b0;
         sh_cnt_q    <= '0;
         fetched_q   <= '0;
      end else begin
         hold_full_q <= hold_full_d;
         sh_cnt_q    <= sh_cnt_d;
         fetched_q   <= fetched_d;
      end
   end

   always_ff @(posedge clk_i) begin
      hold_q  <= hold_d;
      shift_q <= shift_d;
   end

endmodule

// File: rtl/scrambler_frame_ctrl.sv
// Frame sequencer ahead of the scrambler: emits SIGNAL, SERVICE, DATA, TAIL
// and PAD as a registered bit stream with per-bit scrambler qualifiers.
module scrambler_frame_ctrl #(
   parameter  int MAX_LEN = 4095,
   parameter  int SEED_W  = 7,
   localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              start,
   input  logic [3:0]        rate_in,
   input  logic [LEN_W-1:0]  length_in,
   input  logic [7:0]        pad_len_in,
   input  logic [SEED_W-1:0] seed_in,
   input  logic [7:0]        src_data,
   input  logic              src_valid,
   output logic              src_ready,
   output logic              bit_out,
   output logic              bit_valid,
   output logic              scr_load,
   output logic [SEED_W-1:0] scr_seed,
   output logic              scr_bypass,
   output logic              scr_zero,
   output logic [2:0]        field,
   output logic              busy,
   output logic              done
);
   import scr_pkg::*;

   state_e              state_q, state_d;
   logic [4:0]          cnt_q, cnt_d;
   logic [LEN_W+2:0]    dbit_q, dbit_d;
   logic [7:0]          pad_cnt_q, pad_cnt_d;
   logic [3:0]          rate_q;
   logic [LEN_W-1:0]    len_q;
   logic [7:0]          pad_q;
   logic [SEED_W-1:0]   seed_q;

   logic                bit_q, bit_d;
   logic                vld_q, vld_d;
   logic                load_q, load_d;
   logic                byp_q, byp_d;
   logic                zero_q, zero_d;
   logic [2:0]          field_q;
   logic                busy_q;
   logic                done_q, done_d;

   logic                accept;
   logic                adv;
   logic                ser_bit;
   logic                ser_avail;
   logic                fetch_en;
   logic [SIGNAL_BITS-1:0] sig_w;
   logic [LEN_W+2:0]    data_last;

   // The output stage lags the state by one cycle, so a DONE still on the
   // outputs must also block a new start.
   assign accept    = start && (state_q == ST_IDLE) && !done_q;
   assign fetch_en  = (state_q == ST_SIGNAL) || (state_q == ST_SERVICE) || (state_q == ST_DATA);
   assign sig_w     = signal_word(rate_q, len_q);
   assign data_last = {len_q, 3'b000} - 1'b1;

   scr_byte_serializer #(
      .LEN_W (LEN_W)
   ) u_ser (
      .clk_i       (Clk),
      .rst_i       (Reset),
      .clear_i     (accept),
      .fetch_en_i  (fetch_en),
      .len_i       (len_q),
      .src_data_i  (src_data),
      .src_valid_i (src_valid),
      .src_ready_o (src_ready),
      .bit_o       (ser_bit),
      .bit_avail_o (ser_avail),
      .advance_i   (adv)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      dbit_d    = dbit_q;
      pad_cnt_d = pad_cnt_q;
      bit_d     = 1'b0;
      vld_d     = 1'b0;
      load_d    = 1'b0;
      byp_d     = 1'b0;
      zero_d    = 1'b0;
      done_d    = 1'b0;
      adv       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_SIGNAL;
               cnt_d   = '0;
            end
         end
         ST_SIGNAL: begin
            vld_d = 1'b1;
            byp_d = 1'b1;
            bit_d = sig_w[cnt_q];
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'(SIGNAL_BITS - 1)) begin
               load_d  = 1'b1;
               cnt_d   = '0;
               state_d = ST_SERVICE;
            end
         end
         ST_SERVICE: begin
            vld_d = 1'b1;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'(SERVICE_BITS - 1)) begin
               cnt_d   = '0;
               dbit_d  = '0;
               state_d = (len_q == '0) ? ST_TAIL : ST_DATA;
            end
         end
         ST_DATA: begin
            // An empty byte path stalls here with every counter frozen.
            if (ser_avail) begin
               vld_d  = 1'b1;
               bit_d  = ser_bit;
               adv    = 1'b1;
               dbit_d = dbit_q + 1'b1;
               if (dbit_q == data_last) state_d = ST_TAIL;
            end
         end
         ST_TAIL: begin
            vld_d  = 1'b1;
            zero_d = 1'b1;
            cnt_d  = cnt_q + 5'd1;
            if (cnt_q == 5'(TAIL_BITS - 1)) begin
               cnt_d     = '0;
               pad_cnt_d = '0;
               state_d   = (pad_q == 8'd0) ? ST_DONE : ST_PAD;
            end
         end
         ST_PAD: begin
            vld_d     = 1'b1;
            pad_cnt_d = pad_cnt_q + 8'd1;
            if (pad_cnt_q == pad_q - 8'd1) state_d = ST_DONE;
         end
         ST_DONE: begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         dbit_q    <= '0;
         pad_cnt_q <= '0;
         len_q     <= '0;
         pad_q     <= '0;
         seed_q    <= '0;
         bit_q     <= 1'b0;
         vld_q     <= 1'b0;
         load_q    <= 1'b0;
         byp_q     <= 1'b0;
         zero_q    <= 1'b0;
         field_q   <= ST_IDLE;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         dbit_q    <= dbit_d;
         pad_cnt_q <= pad_cnt_d;
         if (accept) begin
            len_q  <= length_in;
            pad_q  <= pad_len_in;
            seed_q <= seed_in;
         end
         bit_q   <= bit_d;
         vld_q   <= vld_d;
         load_q  <= load_d;
         byp_q   <= byp_d;
         zero_q  <= zero_d;
         field_q <= state_q;
         busy_q  <= (state_q != ST_IDLE);
         done_q  <= done_d;
      end
   end

   always_ff @(posedge Clk) begin
      if (accept) rate_q <= rate_in;
   end

   assign bit_out    = bit_q;
   assign bit_valid  = vld_q;
   assign scr_load   = load_q;
   assign scr_seed   = seed_q;
   assign scr_bypass = byp_q;
   assign scr_zero   = zero_q;
   assign field      = field_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_scrambler_frame_ctrl.sv
// Randomized bench for scrambler_frame_ctrl against a queue-based frame model.
module tb_scrambler_frame_ctrl;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        start;
   logic [3:0]  rate_in;
   logic [11:0] length_in;
   logic [7:0]  pad_len_in;
   logic [6:0]  seed_in;
   logic [7:0]  src_data;
   logic        src_valid;
   logic        src_ready;
   logic        bit_out;
   logic        bit_valid;
   logic        scr_load;
   logic [6:0]  scr_seed;
   logic        scr_bypass;
   logic        scr_zero;
   logic [2:0]  field;
   logic        busy;
   logic        done;

   logic [17:0] all_outs;
   assign all_outs = {bit_out, bit_valid, scr_load, scr_seed, scr_bypass, scr_zero,
                      field, busy, done, src_ready};

   scrambler_frame_ctrl dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .start      (start),
      .rate_in    (rate_in),
      .length_in  (length_in),
      .pad_len_in (pad_len_in),
      .seed_in    (seed_in),
      .src_data   (src_data),
      .src_valid  (src_valid),
      .src_ready  (src_ready),
      .bit_out    (bit_out),
      .bit_valid  (bit_valid),
      .scr_load   (scr_load),
      .scr_seed   (scr_seed),
      .scr_bypass (scr_bypass),
      .scr_zero   (scr_zero),
      .field      (field),
      .busy       (busy),
      .done       (done)
   );

   always #5 Clk = ~Clk;

   int          n_chk  = 0;
   int          n_fail = 0;
   logic [7:0]  mem [0:4095];
   logic [6:0]  exp_q [$];   // {field, load, zero, bypass, bit}
   logic [23:0] sig_obs;
   int          last_nvalid;
   int          last_nstall;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic build_model(input logic [3:0] rate, input logic [11:0] len, input logic [7:0] pad);
      logic [3:0]  r;
      logic [11:0] l;
      logic [7:0]  byt;
      logic        b;
      logic        par;
      exp_q.delete();
      r   = rate;
      l   = len;
      par = 1'b0;
      for (int i = 0; i < 24; i++) begin
         if (i < 4) begin
            b = r[3];
            r = r << 1;
         end else if (i == 4) begin
            b = 1'b0;
         end else if (i < 17) begin
            b = l[0];
            l = l >> 1;
         end else if (i == 17) begin
            b = par;
         end else begin
            b = 1'b0;
         end
         if (i < 17) par = par ^ b;
         exp_q.push_back({3'd1, (i == 23), 1'b0, 1'b1, b});
      end
      repeat (16) exp_q.push_back({3'd2, 4'b0000});
      for (int k = 0; k < int'(len); k++) begin
         byt = mem[k];
         for (int j = 0; j < 8; j++) begin
            exp_q.push_back({3'd3, 3'b000, byt[0]});
            byt = byt >> 1;
         end
      end
      repeat (6) exp_q.push_back({3'd4, 4'b0100});
      for (int k = 0; k < int'(pad); k++) exp_q.push_back({3'd5, 4'b0000});
   endtask

   task automatic run_frame(input logic [3:0] rate, input logic [11:0] len, input logic [7:0] pad,
                            input logic [6:0] seed, input int stall_at, input int stall_len,
                            input bit ign, input int rst_at, input string nm);
      int         idx = 0;
      int         nerr = 0;
      int         nbyp = 0;
      int         nzero = 0;
      int         nload = 0;
      int         load_at = -1;
      int         nstall = 0;
      int         bad_stall = 0;
      int         bad_busy = 0;
      int         bad_seed = 0;
      int         nready = 0;
      int         bidx = 0;
      int         stall_left = 0;
      int         budget;
      bit         stall_used = 1'b0;
      bit         got_done = 1'b0;
      bit         prev_vld = 1'b0;
      bit         done_after_vld = 1'b0;
      bit         aborted = 1'b0;
      bit         ign_sig = 1'b0;
      bit         ign_data = 1'b0;
      logic [6:0] rec;

      build_model(rate, len, pad);
      budget = 2 * exp_q.size() + stall_len + 100;
      @(negedge Clk);
      rate_in    = rate;
      length_in  = len;
      pad_len_in = pad;
      seed_in    = seed;
      start      = 1'b1;
      @(negedge Clk);
      start = 1'b0;
      check({nm, "/pre_first_bit"}, {bit_valid, busy, field}, 0);

      for (int cyc = 0; cyc < budget && !got_done && !aborted; cyc++) begin
         if (rst_at >= 0 && idx >= rst_at) begin
            Reset     = 1'b1;
            src_valid = 1'b0;
            start     = 1'b0;
            @(negedge Clk);
            Reset = 1'b0;
            check({nm, "/outs_after_reset"}, all_outs, 0);
            aborted = 1'b1;
         end else begin
            start = 1'b0;
            if (ign && !ign_sig && bit_valid && field == 3'd1) begin
               start   = 1'b1;
               ign_sig = 1'b1;
            end else if (ign && !ign_data && field == 3'd3) begin
               start    = 1'b1;
               ign_data = 1'b1;
            end
            if (start) begin
               rate_in    = ~rate;
               length_in  = len + 12'd7;
               pad_len_in = pad + 8'd3;
               seed_in    = ~seed;
            end
            if (bidx == stall_at && !stall_used) begin
               stall_left = stall_len;
               stall_used = 1'b1;
            end
            if (stall_left > 0) begin
               src_valid = 1'b0;
               stall_left--;
            end else if (bidx < int'(len)) begin
               src_valid = 1'b1;
               src_data  = mem[bidx];
            end else begin
               src_valid = 1'b0;
            end
            if (src_ready) nready++;
            if (src_valid && src_ready) bidx++;

            @(negedge Clk);
            if (cyc == 0) check({nm, "/first_bit"}, {bit_valid, field}, {1'b1, 3'd1});
            if (bit_valid) begin
               rec = {field, scr_load, scr_zero, scr_bypass, bit_out};
               if (idx >= exp_q.size() || rec !== exp_q[idx]) nerr++;
               if (scr_bypass) nbyp++;
               if (scr_zero) nzero++;
               if (scr_load) begin
                  nload++;
                  load_at = idx;
               end
               if (scr_seed !== seed) bad_seed++;
               if (!busy || done) bad_busy++;
               if (idx < 24) sig_obs = {sig_obs[22:0], bit_out};
               idx++;
               prev_vld = 1'b1;
            end else if (done) begin
               got_done       = 1'b1;
               done_after_vld = prev_vld;
               if (!busy) bad_busy++;
            end else begin
               if (!busy) bad_busy++;
               if (field != 3'd3) bad_stall++;
               nstall++;
               prev_vld = 1'b0;
            end
         end
      end

      start     = 1'b0;
      src_valid = 1'b0;
      if (!aborted) begin
         last_nvalid = idx;
         last_nstall = nstall;
         check({nm, "/done_seen"}, got_done, 1);
         check({nm, "/valid_bits"}, idx, exp_q.size());
         check({nm, "/bit_mismatches"}, nerr, 0);
         check({nm, "/bypass_bits"}, nbyp, 24);
         check({nm, "/zero_bits"}, nzero, 6);
         check({nm, "/load_strobes"}, nload, 1);
         check({nm, "/load_position"}, load_at, 23);
         check({nm, "/done_after_last_bit"}, done_after_vld, 1);
         check({nm, "/busy_window"}, bad_busy, 0);
         check({nm, "/stall_outside_data"}, bad_stall, 0);
         check({nm, "/seed_hold"}, bad_seed, 0);
         if (stall_len == 0) check({nm, "/no_stall"}, nstall, 0);
         else check({nm, "/stall_bound"}, (nstall <= stall_len), 1);
         if (len == 12'd0) check({nm, "/ready_never"}, nready, 0);
         if (ign) begin
            rate_in   = 4'hF;
            length_in = 12'd5;
            start     = 1'b1;
         end
         @(negedge Clk);
         start = 1'b0;
         check({nm, "/after_done"}, {done, busy, field}, 0);
         @(negedge Clk);
         check({nm, "/idle_after"}, {bit_valid, busy}, 0);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0]  r;
      logic [11:0] l;
      logic [7:0]  p;
      logic [6:0]  s;
      int          sa;
      int          sl;
      Reset      = 1'b1;
      start      = 1'b0;
      rate_in    = '0;
      length_in  = '0;
      pad_len_in = '0;
      seed_in    = '0;
      src_data   = '0;
      src_valid  = 1'b0;
      sig_obs    = '0;
      repeat (3) @(negedge Clk);
      check("reset/outputs", all_outs, 0);
      check("reset/field", field, 0);
      Reset = 1'b0;
      @(negedge Clk);
      check("reset/idle_hold", all_outs, 0);

      for (int i = 0; i < 100; i++) mem[i] = 8'(i);
      run_frame(4'b1101, 12'd100, 8'd42, 7'b1011101, -1, 0, 1'b0, -1, "nominal");
      check("nominal/signal_field", sig_obs, 24'b1101_0_001001100000_0_000000);
      check("nominal/frame_bits", last_nvalid, 888);

      run_frame(4'b0110, 12'd0, 8'd0, 7'h2A, -1, 0, 1'b0, -1, "minimal");
      check("minimal/frame_bits", last_nvalid, 46);

      for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
      run_frame(4'b0101, 12'd40, 8'd9, 7'h33, 10, 20, 1'b0, -1, "underrun");
      check("underrun/stalled", (last_nstall > 0), 1);
      run_frame(4'b0101, 12'd40, 8'd9, 7'h33, 10, 5, 1'b0, -1, "underrun5");

      run_frame(4'b1011, 12'd3, 8'd1, 7'h11, -1, 0, 1'b0, -1, "pad1");

      run_frame(4'b1001, 12'd20, 8'd5, 7'h5C, -1, 0, 1'b1, -1, "ignore_start");

      run_frame(4'b0011, 12'd30, 8'd4, 7'h7E, -1, 0, 1'b0, 90, "reset_mid");
      run_frame(4'b1110, 12'd12, 8'd7, 7'h01, -1, 0, 1'b0, -1, "after_reset");

      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
         r  = 4'($urandom);
         l  = 12'($urandom_range(0, 50));
         p  = 8'($urandom_range(0, 20));
         s  = 7'($urandom);
         sa = $urandom_range(0, int'(l));
         sl = $urandom_range(0, 15);
         run_frame(r, l, p, s, sa, sl, 1'b0, -1, "random");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/scrambler_frame_ctrl.md
# scrambler_frame_ctrl

Frame sequencer in front of the Scrambler. It builds one PHY frame per `start`: SIGNAL, SERVICE, DATA (fed byte-wise from an upstream source), TAIL and PAD, and presents it as a bit-serial stream with per-bit qualifiers. The Scrambler uses those qualifiers to load its seed, bypass the SIGNAL field and zero the tail bits. `rate`, `length` and `tail_pad_length` originate here, not in the testbench.

## Interface
Parameters:
- `MAX_LEN`, 4095: maximum PSDU length in bytes; sets the `length_in` range.
- `SEED_W`, 7: scrambler seed width.

Ports:
- `Clk`  in  1: single clock. All logic is on the rising edge.
- `Reset`  in  1: synchronous, active-high reset.
- `start`  in  1: frame request. Accepted only in IDLE.
- `rate_in`  in  4: RATE field. Captured at accepted `start`.
- `length_in`  in  12: PSDU length in bytes. Captured at `start`.
- `pad_len_in`  in  8: pad bit count. Captured at `start`.
- `seed_in`  in  7: scrambler seed. Captured at `start`.
- `src_data`  in  8: PSDU byte, sent LSB first.
- `src_valid`  in  1: `src_data` is valid.
- `src_ready`  out  1: controller accepts a byte this cycle when `src_valid` is also high.
- `bit_out`  out  1: serial frame bit.
- `bit_valid`  out  1: `bit_out` is valid. This signal also drives the Scrambler enable.
- `scr_load`  out  1: one-cycle seed-load strobe.
- `scr_seed`  out  7: seed value held from `start`.
- `scr_bypass`  out  1: current bit is not scrambled (SIGNAL field).
- `scr_zero`  out  1: force the scrambled output to 0 (TAIL field).
- `field`  out  3: current state code.
- `busy`  out  1: high from the accepted `start` until `done`.
- `done`  out  1: one-cycle end-of-frame pulse.

## Operation
- States: IDLE, SIGNAL, SERVICE, DATA, TAIL, PAD, DONE.
- IDLE → SIGNAL on `start`.
- SIGNAL (24 bits):
  - bits 0–3 = `rate_in[3:0]`, MSB first.
  - bit 4 = 0.
  - bits 5–16 = `length_in[0..11]`, LSB first.
  - bit 17 = even parity, the XOR of bits 0–16.
  - bits 18–23 = 0.
  - `scr_bypass` = 1 throughout. `scr_load` = 1 on bit 23.
- SERVICE: 16 zero bits, scrambled.
- DATA: 8·L bits. Skipped when L = 0.
- TAIL: 6 zero bits, with `scr_zero` = 1.
- PAD: `pad_len` zero bits. Skipped when `pad_len` = 0.
- DONE: one cycle, with `done` = 1 and `bit_valid` = 0. Then → IDLE.
- Byte path:
  - A 1-byte hold register feeds an 8-bit shift register.
  - `src_ready` = hold empty AND state ∈ {SIGNAL, SERVICE, DATA} AND bytes fetched < L.
  - The shift register loads from hold at each byte boundary.
- Underrun: if hold is empty at a DATA byte boundary, the controller stalls.
  - `bit_valid` = 0 and all counters freeze.
  - No bit is lost or duplicated.
  - Stalls occur only in DATA.
- Counters:
  - 5-bit field bit counter.
  - 15-bit DATA bit counter (max 32760).
  - 12-bit fetched-byte counter.
  - 8-bit pad counter.
- `start` outside IDLE is ignored, including during DONE.
- Reset mid-frame: next state IDLE, hold register emptied, partial frame abandoned.

## Timing
- Reset values: every output is 0, and `field` = IDLE.
- Start latency: `start` sampled high at edge N gives the first SIGNAL bit valid after edge N+1. Registered outputs change only at clock edges.
- `busy` rises at the same edge as the first bit. It falls at the edge where `done` falls.
- Stall-free frame length: 24 + 16 + 8L + 6 + P valid cycles, then one DONE cycle.
- Qualifiers `scr_bypass`, `scr_zero` and `scr_load` are cycle-aligned with `bit_out`.
- Byte handshake: a transfer occurs on the edge where `src_valid` and `src_ready` are both high. `src_ready` depends only on registered state.
- Simultaneous hold refill and shift-register load in the same cycle is allowed. The hold register stays full with the new byte.

## Structure
- Package `scr_pkg` holds:
  - the state enum codes (IDLE=0, SIGNAL=1, SERVICE=2, DATA=3, TAIL=4, PAD=5, DONE=6);
  - field lengths (SIGNAL=24, SERVICE=16, TAIL=6);
  - the SIGNAL bit-index constants.
- One sub-module, `scr_byte_serializer`, contains the hold register, shift register and fetch handshake. It exposes `bit`, `bit_avail` and `advance`.

## Test plan
- Nominal frame: rate=4'b1101, length=100, pad=42, seed=7'b1011101, bytes 0x00..0x63.
  - SIGNAL bits = 1101 0 001001100000 0 000000 (parity 0).
  - 888 valid bits, then `done` exactly one cycle later.
  - `scr_load` high exactly at bit 23.
- Minimal frame: length=0, pad=0 → 46 valid bits (SIGNAL, SERVICE, TAIL), then DONE. `src_ready` never asserted.
- Underrun: drop `src_valid` for 5 cycles at byte 10 → `bit_valid` low for exactly the stall cycles. Output bit sequence identical to the no-stall run.
- Qualifier windows:
  - `scr_bypass` high for exactly 24 valid bits.
  - `scr_zero` high for exactly 6.
  - both low during PAD (pad=1 case: a single PAD bit).
- `start` pulsed during SIGNAL, DATA and DONE → ignored. Captured fields and bit count unchanged.
- Reset asserted mid-DATA → next cycle all outputs 0, `field` = IDLE. A following `start` produces a correct full frame.
